// File: rtl/qoi_stream_writer.sv
// qoi_stream_writer: writes QOI header, buffered encoder bytes and (when QOI_END_MARKER_EN is defined) the end marker to memory via cs/gnt handshake
module qoi_stream_writer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIM_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [7:0]        channels,
  input  logic [7:0]        colorspace,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              done,
  output logic [31:0]       byte_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, HDR, STREAM, TAIL, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
  logic [7:0] ch_q, ch_d, cs_q, cs_d;
  logic [3:0] idx_q, idx_d, idx_rev;
  logic [31:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic [PW:0] wp_q, wp_d, rp_q, rp_d, occ;
  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [7:0] fifo_d [FIFO_DEPTH];
  logic empty, full, push, pop, gnt;
  logic [111:0] hdr_v;
  always_comb begin
    occ        = wp_q - rp_q;
    empty      = occ == '0;
    full       = occ == (PW+1)'(FIFO_DEPTH);
    busy       = state_q != IDLE;
    done       = state_q == FIN;
    in_ready   = busy && !full && !last_q;
    push       = in_valid && in_ready;
    mem_cs     = (state_q == HDR) || (state_q == TAIL) || (state_q == STREAM && !empty);
    mem_we     = mem_cs;
    mem_addr   = addr_q;
    byte_count = cnt_q;
    gnt        = mem_cs && mem_gnt;
    pop        = gnt && state_q == STREAM;
    idx_rev    = 4'd13 - idx_q;
    hdr_v      = {32'h716F6966, 32'(width_q), 32'(height_q), ch_q, cs_q};
    mem_data   = state_q == HDR ? 8'(hdr_v >> {idx_rev, 3'b000}) :
                 (state_q == STREAM && !empty) ? fifo_q[rp_q[PW-1:0]] :
                 (state_q == TAIL && idx_q == 4'd7) ? 8'h01 : 8'h00;
  end
  always_comb begin
    state_d  = state_q;
    addr_d   = gnt ? addr_q + ADDR_W'(1) : addr_q;
    cnt_d    = gnt ? cnt_q + 32'd1 : cnt_q;
    width_d  = width_q;
    height_d = height_q;
    ch_d     = ch_q;
    cs_d     = cs_q;
    idx_d    = idx_q;
    last_d   = last_q || (push && in_last);
    wp_d     = push ? wp_q + (PW+1)'(1) : wp_q;
    rp_d     = pop ? rp_q + (PW+1)'(1) : rp_q;
    fifo_d   = fifo_q;
    if (push) fifo_d[wp_q[PW-1:0]] = in_data;
    case (state_q)
      IDLE: if (start) begin
        state_d  = HDR;
        addr_d   = base_addr;
        width_d  = img_width;
        height_d = img_height;
        ch_d     = channels;
        cs_d     = colorspace;
        cnt_d    = '0;
        last_d   = 1'b0;
        idx_d    = '0;
        wp_d     = '0;
        rp_d     = '0;
      end
      HDR: if (gnt) begin
        idx_d   = idx_q == 4'd13 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd13 ? STREAM : HDR;
      end
      STREAM: if (last_q && (empty || (pop && occ == (PW+1)'(1)))) begin
`ifdef QOI_END_MARKER_EN
        state_d = TAIL;
`else
        state_d = FIN;
`endif
      end
      TAIL: if (gnt) begin
        idx_d   = idx_q == 4'd7 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd7 ? FIN : TAIL;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      ch_q     <= '0;
      cs_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      height_q <= height_d;
      ch_q     <= ch_d;
      cs_q     <= cs_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
    end
  end
  always_ff @(posedge clk) fifo_q <= fifo_d;
endmodule
